// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment date capture block.
//   - SEG_0..SEG_9 : legal segment patterns {a,b,c,d,e,f,g}, a = bit 6
//   - SEL_*        : digit-select positions of each BCD nibble in the frame
//   - DP_EXPECTED  : the only decimal-point mask a legal frame may carry
//   - state_e      : capture FSM states
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;

  localparam logic [2:0] SEL_YEAR_T = 3'd0;
  localparam logic [2:0] SEL_YEAR_O = 3'd1;
  localparam logic [2:0] SEL_MON_T  = 3'd2;
  localparam logic [2:0] SEL_MON_O  = 3'd3;
  localparam logic [2:0] SEL_DAY_T  = 3'd4;
  localparam logic [2:0] SEL_DAY_O  = 3'd5;

  localparam logic [5:0] DP_EXPECTED = 6'b001010;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2
  } state_e;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational seven-segment to BCD decoder.
//   seg_i     : segment pattern {a,b,c,d,e,f,g}
//   bcd_o     : decoded digit (0 when illegal)
//   illegal_o : pattern is not one of the ten legal digit codes
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] bcd_o,
  output logic       illegal_o
);

  // Map a segment pattern back to its digit; every other pattern, blank included, is illegal.
  always_comb begin
    bcd_o     = 4'd0;
    illegal_o = 1'b0;
    case (seg_i)
      SEG_0:   bcd_o = 4'd0;
      SEG_1:   bcd_o = 4'd1;
      SEG_2:   bcd_o = 4'd2;
      SEG_3:   bcd_o = 4'd3;
      SEG_4:   bcd_o = 4'd4;
      SEG_5:   bcd_o = 4'd5;
      SEG_6:   bcd_o = 4'd6;
      SEG_7:   bcd_o = 4'd7;
      SEG_8:   bcd_o = 4'd8;
      SEG_9:   bcd_o = 4'd9;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_date_capture.sv
// Receiver for the multiplexed 6-digit YY.MM.DD seven-segment display bus.
// Samples the scan lines, waits for each digit to settle, reassembles a frame
// in the order sel 5..0, and publishes it with a one-cycle frame_valid strobe.
//   clk, reset           : clock, asynchronous active-high reset
//   seg7_sel/in, dpt_in  : scanned select, segment pattern, decimal point
//   frame_valid          : one-cycle pulse on each committed frame
//   year/month/day_bcd   : {tens,ones} of the last committed frame
//   dp_mask              : decimal points of the last committed frame
//   date_error           : last committed frame is not a legal date / dp mask
//   seg_error            : one-cycle pulse when a frame is aborted
module seg7_date_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] seg7_sel,
  input  logic [6:0] seg7_in,
  input  logic       dpt_in,
  output logic       frame_valid,
  output logic [7:0] year_bcd,
  output logic [7:0] month_bcd,
  output logic [7:0] day_bcd,
  output logic [5:0] dp_mask,
  output logic       date_error,
  output logic       seg_error
);

  localparam logic [3:0] STAB_TGT = 4'(STABLE_CYCLES - 1);

  logic [2:0]       r_sel_q;
  logic [6:0]       r_seg_q;
  logic             r_dp_q;
  logic [3:0]       stab_cnt_q, stab_cnt_d;
  logic             accept_s;
  logic [3:0]       dec_bcd_s;
  logic             dec_illegal_s;
  state_e           state_q, state_d;
  logic [2:0]       exp_q, exp_d;
  logic             store_s, abort_s, commit_s;
  logic [5:0][3:0]  dig_q;
  logic [5:0]       dp_sh_q;
  logic             frame_valid_q, seg_error_q, date_error_q;
  logic [7:0]       year_q, month_q, day_q;
  logic [5:0]       dp_mask_q;
  logic [3:0]       yr_t_s, yr_o_s, mo_t_s, mo_o_s, dy_t_s, dy_o_s;
  logic [6:0]       day_bin_s;
  logic [3:0]       month_bin_s;
  logic [4:0]       month_len_s;
  logic             month_ok_s, leap_s, date_bad_s;

  // The counter compares the triple being registered with the one already held,
  // so a digit stable from edge E0 reaches the threshold at edge E0+STABLE_CYCLES-1.
  assign stab_cnt_d = ({seg7_sel, seg7_in, dpt_in} != {r_sel_q, r_seg_q, r_dp_q}) ? 4'd0 :
                      (stab_cnt_q == 4'd15) ? 4'd15 : stab_cnt_q + 4'd1;
  // Saturation keeps this a single-cycle event per dwell.
  assign accept_s = (stab_cnt_d == STAB_TGT);

  seg7_to_bcd u_dec (
    .seg_i     (r_seg_q),
    .bcd_o     (dec_bcd_s),
    .illegal_o (dec_illegal_s)
  );

  // Input sampling and stability counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel_q    <= 3'd0;
      r_seg_q    <= 7'd0;
      r_dp_q     <= 1'b0;
      stab_cnt_q <= 4'd0;
    end else begin
      r_sel_q    <= seg7_sel;
      r_seg_q    <= seg7_in;
      r_dp_q     <= dpt_in;
      stab_cnt_q <= stab_cnt_d;
    end
  end

  // Frame assembly FSM: next state and per-accept actions.
  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    store_s  = 1'b0;
    abort_s  = 1'b0;
    commit_s = 1'b0;
    case (state_q)
      HUNT: begin
        if (accept_s && (r_sel_q == SEL_DAY_O) && !dec_illegal_s) begin
          store_s = 1'b1;
          exp_d   = SEL_DAY_T;
          state_d = COLLECT;
        end else begin
          state_d = HUNT;
        end
      end
      COLLECT: begin
        if (!accept_s) begin
          state_d = COLLECT;
        end else if ((r_sel_q == exp_q) && !dec_illegal_s) begin
          store_s = 1'b1;
          if (r_sel_q == SEL_YEAR_T) begin
            state_d = COMMIT;
          end else begin
            exp_d = exp_q - 3'd1;
          end
        end else if ((r_sel_q == SEL_DAY_O) && !dec_illegal_s) begin
          // A fresh sel 5 simply restarts the frame.
          store_s = 1'b1;
          exp_d   = SEL_DAY_T;
        end else begin
          abort_s = 1'b1;
          state_d = HUNT;
        end
      end
      COMMIT: begin
        // Any sel 5 accepted here is deliberately dropped.
        commit_s = 1'b1;
        state_d  = HUNT;
      end
      default: state_d = HUNT;
    endcase
  end

  // FSM state, expected select and shadow digit storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HUNT;
      exp_q   <= SEL_DAY_O;
      dig_q   <= '0;
      dp_sh_q <= 6'd0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      if (store_s) begin
        dig_q[r_sel_q]   <= dec_bcd_s;
        dp_sh_q[r_sel_q] <= r_dp_q;
      end
    end
  end

  assign yr_t_s    = dig_q[SEL_YEAR_T];
  assign yr_o_s    = dig_q[SEL_YEAR_O];
  assign mo_t_s    = dig_q[SEL_MON_T];
  assign mo_o_s    = dig_q[SEL_MON_O];
  assign dy_t_s    = dig_q[SEL_DAY_T];
  assign dy_o_s    = dig_q[SEL_DAY_O];
  assign day_bin_s = ({3'b000, dy_t_s} * 7'd10) + {3'b000, dy_o_s};

  // Calendar legality of the shadow frame; the leap rule works directly on BCD digits.
  always_comb begin
    leap_s      = 1'b0;
    month_ok_s  = 1'b0;
    month_bin_s = 4'd0;
    month_len_s = 5'd0;
    if (yr_t_s[0] == 1'b0) begin
      leap_s = (yr_o_s == 4'd0) || (yr_o_s == 4'd4) || (yr_o_s == 4'd8);
    end else begin
      leap_s = (yr_o_s == 4'd2) || (yr_o_s == 4'd6);
    end
    if ((mo_t_s == 4'd0) && (mo_o_s != 4'd0)) begin
      month_ok_s  = 1'b1;
      month_bin_s = mo_o_s;
    end else if ((mo_t_s == 4'd1) && (mo_o_s <= 4'd2)) begin
      month_ok_s  = 1'b1;
      month_bin_s = 4'd10 + mo_o_s;
    end else begin
      month_ok_s = 1'b0;
    end
    case (month_bin_s)
      4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: month_len_s = 5'd31;
      4'd4, 4'd6, 4'd9, 4'd11:                    month_len_s = 5'd30;
      4'd2:    month_len_s = leap_s ? 5'd29 : 5'd28;
      default: month_len_s = 5'd0;
    endcase
    date_bad_s = !month_ok_s || (day_bin_s == 7'd0) ||
                 (day_bin_s > {2'b00, month_len_s}) || (dp_sh_q != DP_EXPECTED);
  end

  // Published outputs: updated only when a frame commits; strobes last one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_valid_q <= 1'b0;
      seg_error_q   <= 1'b0;
      date_error_q  <= 1'b0;
      year_q        <= 8'h00;
      month_q       <= 8'h00;
      day_q         <= 8'h00;
      dp_mask_q     <= 6'd0;
    end else begin
      frame_valid_q <= commit_s;
      seg_error_q   <= abort_s;
      if (commit_s) begin
        year_q       <= {yr_t_s, yr_o_s};
        month_q      <= {mo_t_s, mo_o_s};
        day_q        <= {dy_t_s, dy_o_s};
        dp_mask_q    <= dp_sh_q;
        date_error_q <= date_bad_s;
      end
    end
  end

  assign frame_valid = frame_valid_q;
  assign seg_error   = seg_error_q;
  assign date_error  = date_error_q;
  assign year_bcd    = year_q;
  assign month_bcd   = month_q;
  assign day_bcd     = day_q;
  assign dp_mask     = dp_mask_q;

endmodule

// File: tb/tb_seg7_date_capture.sv
// Directed self-checking bench for seg7_date_capture (STABLE_CYCLES = 4).
module tb_seg7_date_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] seg7_sel;
  logic [6:0] seg7_in;
  logic       dpt_in;
  logic       frame_valid;
  logic [7:0] year_bcd, month_bcd, day_bcd;
  logic [5:0] dp_mask;
  logic       date_error, seg_error;

  int checks = 0;
  int errors = 0;
  int fv_cnt = 0;
  int se_cnt = 0;
  int fv0, se0;

  seg7_date_capture #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .seg7_sel    (seg7_sel),
    .seg7_in     (seg7_in),
    .dpt_in      (dpt_in),
    .frame_valid (frame_valid),
    .year_bcd    (year_bcd),
    .month_bcd   (month_bcd),
    .day_bcd     (day_bcd),
    .dp_mask     (dp_mask),
    .date_error  (date_error),
    .seg_error   (seg_error)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled on the inactive edge.
  always @(negedge clk) begin
    if (frame_valid === 1'b1) fv_cnt <= fv_cnt + 1;
    if (seg_error === 1'b1)   se_cnt <= se_cnt + 1;
  end

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0: enc = 7'b1111110;
      4'd1: enc = 7'b0110000;
      4'd2: enc = 7'b1101101;
      4'd3: enc = 7'b1111001;
      4'd4: enc = 7'b0110011;
      4'd5: enc = 7'b1011011;
      4'd6: enc = 7'b1011111;
      4'd7: enc = 7'b1110000;
      4'd8: enc = 7'b1111111;
      4'd9: enc = 7'b1111011;
      default: enc = 7'b0000000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] sel, input logic [6:0] seg, input logic dp, input int dwell);
    seg7_sel = sel;
    seg7_in  = seg;
    dpt_in   = dp;
    repeat (dwell) step();
  endtask

  task automatic scan(input logic [7:0] yy, input logic [7:0] mm, input logic [7:0] dd,
                      input logic [5:0] dpm);
    logic [3:0] dg [6];
    dg[0] = yy[7:4]; dg[1] = yy[3:0];
    dg[2] = mm[7:4]; dg[3] = mm[3:0];
    dg[4] = dd[7:4]; dg[5] = dd[3:0];
    for (int s = 5; s >= 0; s--) drive(3'(s), enc(dg[s]), dpm[s], 8);
  endtask

  task automatic chk_out(input string tag, input logic [7:0] yy, input logic [7:0] mm,
                         input logic [7:0] dd, input logic [5:0] dpm, input logic derr);
    chk({tag, "_year"},  year_bcd,   yy);
    chk({tag, "_month"}, month_bcd,  mm);
    chk({tag, "_day"},   day_bcd,    dd);
    chk({tag, "_dp"},    dp_mask,    dpm);
    chk({tag, "_derr"},  date_error, derr);
  endtask

  initial begin
    reset = 1'b1; seg7_sel = 3'd0; seg7_in = 7'b0000000; dpt_in = 1'b0;
    repeat (3) step();
    chk("rst_fv", frame_valid, 1'b0);
    chk("rst_se", seg_error, 1'b0);
    chk_out("rst", 8'h00, 8'h00, 8'h00, 6'd0, 1'b0);
    reset = 1'b0;
    repeat (4) step();

    // Legal frame 21.01.01 with exact commit latency on the sel 0 dwell.
    fv0 = fv_cnt; se0 = se_cnt;
    drive(3'd5, enc(4'd1), 1'b0, 8);
    drive(3'd4, enc(4'd0), 1'b0, 8);
    drive(3'd3, enc(4'd1), 1'b1, 8);
    drive(3'd2, enc(4'd0), 1'b0, 8);
    drive(3'd1, enc(4'd1), 1'b1, 8);
    seg7_sel = 3'd0; seg7_in = enc(4'd2); dpt_in = 1'b0;
    repeat (4) step();
    chk("lat_fv_early", frame_valid, 1'b0);
    chk("lat_year_early", year_bcd, 8'h00);
    step();
    chk("lat_fv_pulse", frame_valid, 1'b1);
    chk("lat_year", year_bcd, 8'h21);
    step();
    chk("lat_fv_drop", frame_valid, 1'b0);
    repeat (2) step();
    chk("f1_fv_count", fv_cnt - fv0, 1);
    chk("f1_se_count", se_cnt - se0, 0);
    chk_out("f1", 8'h21, 8'h01, 8'h01, 6'b001010, 1'b0);

    // Leap year 24: Feb 29 is legal.
    fv0 = fv_cnt;
    scan(8'h24, 8'h02, 8'h29, 6'b001010);
    chk("leap_fv", fv_cnt - fv0, 1);
    chk_out("leap", 8'h24, 8'h02, 8'h29, 6'b001010, 1'b0);

    // Non-leap 25: Feb 29 illegal but still published.
    fv0 = fv_cnt;
    scan(8'h25, 8'h02, 8'h29, 6'b001010);
    chk("noleap_fv", fv_cnt - fv0, 1);
    chk_out("noleap", 8'h25, 8'h02, 8'h29, 6'b001010, 1'b1);

    // Blank pattern on sel 3 aborts; rest of that scan is ignored.
    fv0 = fv_cnt; se0 = se_cnt;
    drive(3'd5, enc(4'd2), 1'b0, 8);
    drive(3'd4, enc(4'd1), 1'b0, 8);
    drive(3'd3, 7'b0000000, 1'b1, 8);
    drive(3'd2, enc(4'd1), 1'b0, 8);
    drive(3'd1, enc(4'd2), 1'b1, 8);
    drive(3'd0, enc(4'd1), 1'b0, 8);
    chk("illeg_se", se_cnt - se0, 1);
    chk("illeg_fv", fv_cnt - fv0, 0);
    chk_out("illeg_hold", 8'h25, 8'h02, 8'h29, 6'b001010, 1'b1);
    fv0 = fv_cnt;
    scan(8'h12, 8'h12, 8'h31, 6'b001010);
    chk("after_illeg_fv", fv_cnt - fv0, 1);
    chk_out("after_illeg", 8'h12, 8'h12, 8'h31, 6'b001010, 1'b0);

    // Out-of-order 5,4,2 aborts at the sel 2 accept; next full scan commits (00 is leap).
    fv0 = fv_cnt; se0 = se_cnt;
    drive(3'd5, enc(4'd9), 1'b0, 8);
    drive(3'd4, enc(4'd0), 1'b0, 8);
    drive(3'd2, enc(4'd0), 1'b0, 8);
    chk("ooo_se", se_cnt - se0, 1);
    chk("ooo_fv", fv_cnt - fv0, 0);
    scan(8'h00, 8'h02, 8'h29, 6'b001010);
    chk("ooo_next_fv", fv_cnt - fv0, 1);
    chk("ooo_next_se", se_cnt - se0, 1);
    chk_out("ooo_next", 8'h00, 8'h02, 8'h29, 6'b001010, 1'b0);

    // Short dwell (3 clk) on sel 2: seg_error at the sel 1 accept, no commit.
    fv0 = fv_cnt; se0 = se_cnt;
    drive(3'd5, enc(4'd5), 1'b0, 8);
    drive(3'd4, enc(4'd1), 1'b0, 8);
    drive(3'd3, enc(4'd5), 1'b1, 8);
    drive(3'd2, enc(4'd0), 1'b0, 3);
    drive(3'd1, enc(4'd3), 1'b1, 8);
    chk("short_se", se_cnt - se0, 1);
    drive(3'd0, enc(4'd2), 1'b0, 8);
    chk("short_fv", fv_cnt - fv0, 0);
    chk_out("short_hold", 8'h00, 8'h02, 8'h29, 6'b001010, 1'b0);

    // Month 13, wrong dp mask, Feb 29 on non-leap 01, and April 31.
    scan(8'h99, 8'h13, 8'h01, 6'b001010);
    chk_out("mon13", 8'h99, 8'h13, 8'h01, 6'b001010, 1'b1);
    scan(8'h21, 8'h01, 8'h01, 6'b000000);
    chk_out("dpbad", 8'h21, 8'h01, 8'h01, 6'b000000, 1'b1);
    scan(8'h01, 8'h02, 8'h29, 6'b001010);
    chk_out("y01feb29", 8'h01, 8'h02, 8'h29, 6'b001010, 1'b1);
    scan(8'h30, 8'h04, 8'h31, 6'b001010);
    chk_out("apr31", 8'h30, 8'h04, 8'h31, 6'b001010, 1'b1);
    scan(8'h19, 8'h03, 8'h00, 6'b001010);
    chk_out("day00", 8'h19, 8'h03, 8'h00, 6'b001010, 1'b1);

    // Reset mid-frame after sel 3 accepted: outputs clear at once, partial frame gone.
    drive(3'd5, enc(4'd0), 1'b0, 8);
    drive(3'd4, enc(4'd3), 1'b0, 8);
    drive(3'd3, enc(4'd1), 1'b1, 8);
    drive(3'd2, enc(4'd1), 1'b0, 2);
    reset = 1'b1;
    #1;
    chk("midrst_fv", frame_valid, 1'b0);
    chk_out("midrst", 8'h00, 8'h00, 8'h00, 6'd0, 1'b0);
    repeat (2) step();
    reset = 1'b0;
    fv0 = fv_cnt; se0 = se_cnt;
    drive(3'd2, enc(4'd1), 1'b0, 8);
    drive(3'd1, enc(4'd9), 1'b1, 8);
    drive(3'd0, enc(4'd1), 1'b0, 8);
    chk("midrst_nocommit", fv_cnt - fv0, 0);
    chk("midrst_nose", se_cnt - se0, 0);
    chk_out("midrst_hold", 8'h00, 8'h00, 8'h00, 6'd0, 1'b0);
    scan(8'h19, 8'h11, 8'h30, 6'b001010);
    chk("postrst_fv", fv_cnt - fv0, 1);
    chk_out("postrst", 8'h19, 8'h11, 8'h30, 6'b001010, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
